// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch sequencer and its predecoder.
package fetch_pkg;

  typedef enum logic [2:0] {
    RST_HI,
    RST_LO,
    RUN,
    IMM,
    INT_HI,
    INT_LO
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VEC_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_INT_VEC_ADDR   = 32'h0000_0002;
  localparam logic [15:0] DEFAULT_IMM_MASK       = 16'h0001;
  localparam logic [15:0] DEFAULT_IMM_MATCH      = 16'h0001;
  localparam logic [15:0] DEFAULT_NOP_WORD       = 16'h0000;

endpackage

// File: rtl/two_word_predecode.sv
// Flags an instruction word whose marker bits say an immediate word follows it.
module two_word_predecode
  import fetch_pkg::*;
#(
  parameter logic [15:0] IMM_MASK  = DEFAULT_IMM_MASK,
  parameter logic [15:0] IMM_MATCH = DEFAULT_IMM_MATCH
) (
  input  logic [15:0] memData,
  output logic        isTwoWord
);

  assign isTwoWord = ((memData & IMM_MASK) == IMM_MATCH);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: vector boot, PC advance, two-word assembly into IF/ID,
// plus jump / stall / interrupt policy.
//
// state  | meaning
// RST_HI | fetch reset vector high half
// RST_LO | fetch reset vector low half, load PC
// RUN    | instruction boundary: fetch opcode word
// IMM    | fetch immediate word of a two-word instruction
// INT_HI | fetch interrupt vector high half
// INT_LO | fetch interrupt vector low half, load PC
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC_ADDR = DEFAULT_RESET_VEC_ADDR,
  parameter logic [31:0] INT_VEC_ADDR   = DEFAULT_INT_VEC_ADDR,
  parameter logic [15:0] IMM_MASK       = DEFAULT_IMM_MASK,
  parameter logic [15:0] IMM_MATCH      = DEFAULT_IMM_MATCH,
  parameter logic [15:0] NOP_WORD       = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jumpBit,
  input  logic [31:0] jumpTarget,
  input  logic        interruptBit,
  input  logic [15:0] memData,
  output logic [31:0] pc,
  output logic [31:0] samePc,
  output logic [31:0] nextPc,
  output logic [15:0] instruction,
  output logic [15:0] immediate,
  output logic        instrValid,
  output logic        pushPc,
  output logic [31:0] savedPc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  same_pc_q, same_pc_d;
  logic [31:0]  next_pc_q, next_pc_d;
  logic [31:0]  saved_pc_q, saved_pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  imm_q, imm_d;
  logic [15:0]  vec_hi_q, vec_hi_d;
  logic         valid_q, valid_d;
  logic         push_pc_q, push_pc_d;
  logic         int_pending_q, int_pending_d;
  logic         int_block_q, int_block_d;
  logic         is_two_word;
  logic [31:0]  pc_inc;

  two_word_predecode #(
    .IMM_MASK (IMM_MASK),
    .IMM_MATCH(IMM_MATCH)
  ) u_predecode (
    .memData  (memData),
    .isTwoWord(is_two_word)
  );

  assign pc_inc = pc_q + 32'd1;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    same_pc_d     = same_pc_q;
    next_pc_d     = next_pc_q;
    saved_pc_d    = saved_pc_q;
    instr_d       = instr_q;
    imm_d         = imm_q;
    vec_hi_d      = vec_hi_q;
    valid_d       = valid_q;
    push_pc_d     = 1'b0;
    int_pending_d = int_pending_q | interruptBit;
    int_block_d   = int_block_q;

    case (state_q)
      RST_HI, INT_HI: begin
        vec_hi_d = memData;
        pc_d     = pc_inc;
        state_d  = (state_q == RST_HI) ? RST_LO : INT_LO;
      end
      RST_LO, INT_LO: begin
        pc_d    = {vec_hi_q, memData};
        state_d = RUN;
        // the handler must fetch one instruction before a nested interrupt
        int_block_d = (state_q == INT_LO);
      end
      RUN, IMM: begin
        if (jumpBit) begin
          pc_d    = jumpTarget;
          instr_d = NOP_WORD;
          imm_d   = 16'h0000;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (stall) begin
          state_d = state_q;
        end else if (state_q == RUN && (int_pending_q || interruptBit) && !int_block_q) begin
          saved_pc_d    = pc_q;
          push_pc_d     = 1'b1;
          pc_d          = INT_VEC_ADDR;
          int_pending_d = 1'b0;
          instr_d       = NOP_WORD;
          valid_d       = 1'b0;
          state_d       = INT_HI;
        end else if (state_q == RUN) begin
          instr_d     = memData;
          same_pc_d   = pc_q;
          next_pc_d   = pc_inc;
          pc_d        = pc_inc;
          int_block_d = 1'b0;
          if (is_two_word) begin
            valid_d = 1'b0;
            state_d = IMM;
          end else begin
            imm_d   = 16'h0000;
            valid_d = 1'b1;
          end
        end else begin
          imm_d     = memData;
          pc_d      = pc_inc;
          next_pc_d = pc_inc;
          valid_d   = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RST_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_HI;
      pc_q          <= RESET_VEC_ADDR;
      same_pc_q     <= 32'h0;
      next_pc_q     <= 32'h0;
      saved_pc_q    <= 32'h0;
      instr_q       <= NOP_WORD;
      imm_q         <= 16'h0;
      vec_hi_q      <= 16'h0;
      valid_q       <= 1'b0;
      push_pc_q     <= 1'b0;
      int_pending_q <= 1'b0;
      int_block_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      same_pc_q     <= same_pc_d;
      next_pc_q     <= next_pc_d;
      saved_pc_q    <= saved_pc_d;
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      vec_hi_q      <= vec_hi_d;
      valid_q       <= valid_d;
      push_pc_q     <= push_pc_d;
      int_pending_q <= int_pending_d;
      int_block_q   <= int_block_d;
    end
  end

  assign pc          = pc_q;
  assign samePc      = same_pc_q;
  assign nextPc      = next_pc_q;
  assign savedPc     = saved_pc_q;
  assign instruction = instr_q;
  assign immediate   = imm_q;
  assign instrValid  = valid_q;
  assign pushPc      = push_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: boot, one/two-word fetch, stall, jump,
// interrupts, mid-run reset and PC wrap, with a scoreboard of expected IF/ID contents.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, jumpBit, interruptBit;
  logic [31:0] jumpTarget;
  logic [15:0] memData;
  logic [31:0] pc, samePc, nextPc, savedPc;
  logic [15:0] instruction, immediate;
  logic        instrValid, pushPc;

  logic [15:0] mem [256];

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] same;
    logic [31:0] nxt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jumpBit     (jumpBit),
    .jumpTarget  (jumpTarget),
    .interruptBit(interruptBit),
    .memData     (memData),
    .pc          (pc),
    .samePc      (samePc),
    .nextPc      (nextPc),
    .instruction (instruction),
    .immediate   (immediate),
    .instrValid  (instrValid),
    .pushPc      (pushPc),
    .savedPc     (savedPc)
  );

  always #5 clk = ~clk;

  always_comb memData = mem[pc[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advances at least one cycle; cyc = cycles until instrValid, or -1 on timeout
  task automatic wait_valid(input int budget, output int cycles);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!instrValid && n < budget);
    cycles = instrValid ? n : -1;
  endtask

  task automatic sb_compare(input string name);
    n_checks++;
    if (cyc < 0 || sb.size() == 0) begin
      $display("FAIL %s: no valid instruction (cyc=%0d, queued=%0d)", name, cyc, sb.size());
    end else begin
      e = sb.pop_front();
      if ({instruction, immediate, samePc, nextPc} !== e)
        $display("FAIL %s: got instr=%h imm=%h same=%h next=%h, exp instr=%h imm=%h same=%h next=%h",
                 name, instruction, immediate, samePc, nextPc, e.instr, e.imm, e.same, e.nxt);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); else n_pass++;
    n_checks++;
    if ({instrValid, pushPc, instruction, immediate, samePc, nextPc, savedPc} !== 130'h0)
      $display("FAIL reset_outputs got valid=%b push=%b instr=%h imm=%h same=%h next=%h saved=%h exp all zero",
               instrValid, pushPc, instruction, immediate, samePc, nextPc, savedPc);
    else n_pass++;
  endtask

  task automatic test_boot();
    rst = 1'b0;
    tick();
    n_checks++; if ({pc, instrValid} !== {32'h1, 1'b0}) $display("FAIL boot_hi got pc=%h valid=%b exp pc=1 valid=0", pc, instrValid); else n_pass++;
    tick();
    n_checks++; if ({pc, instrValid} !== {32'h10, 1'b0}) $display("FAIL boot_lo got pc=%h valid=%b exp pc=10 valid=0", pc, instrValid); else n_pass++;
  endtask

  task automatic test_two_word();
    sb.push_back(exp_t'{16'h3811, 16'h0004, 32'h10, 32'h12});
    wait_valid(4, cyc);
    n_checks++; if (cyc != 2) $display("FAIL two_word_latency got=%0d exp=2", cyc); else n_pass++;
    sb_compare("two_word_ifid");
    n_checks++; if (pc !== 32'h12) $display("FAIL two_word_pc got=%h exp=%h", pc, 32'h12); else n_pass++;
  endtask

  task automatic test_one_word();
    sb.push_back(exp_t'{16'h1234, 16'h0000, 32'h12, 32'h13});
    wait_valid(3, cyc);
    n_checks++; if (cyc != 1) $display("FAIL one_word_latency got=%0d exp=1", cyc); else n_pass++;
    sb_compare("one_word_ifid");
  endtask

  task automatic test_stall_jump();
    tick();
    n_checks++; if ({pc, instruction, instrValid} !== {32'h14, 16'h2001, 1'b0}) $display("FAIL imm_entry got pc=%h instr=%h valid=%b exp pc=14 instr=2001 valid=0", pc, instruction, instrValid); else n_pass++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({pc, instruction, samePc, instrValid} !== {32'h14, 16'h2001, 32'h13, 1'b0})
        $display("FAIL stall_hold[%0d] got pc=%h instr=%h same=%h valid=%b exp pc=14 instr=2001 same=13 valid=0", i, pc, instruction, samePc, instrValid);
      else n_pass++;
    end
    jumpBit = 1'b1;
    jumpTarget = 32'h40;
    tick();
    jumpBit = 1'b0;
    stall = 1'b0;
    n_checks++; if ({pc, instruction, instrValid} !== {32'h40, 16'h0000, 1'b0}) $display("FAIL jump_redirect got pc=%h instr=%h valid=%b exp pc=40 instr=0 valid=0", pc, instruction, instrValid); else n_pass++;
    n_checks++; if (dut.state_q !== RUN) $display("FAIL jump_state got=%0d exp=%0d", dut.state_q, RUN); else n_pass++;
    sb.push_back(exp_t'{16'h0042, 16'h0000, 32'h40, 32'h41});
    wait_valid(3, cyc);
    sb_compare("after_jump_ifid");
  endtask

  task automatic test_interrupt();
    jumpBit = 1'b1;
    jumpTarget = 32'h20;
    tick();
    jumpBit = 1'b0;
    interruptBit = 1'b1;
    tick();
    interruptBit = 1'b0;
    n_checks++;
    if ({pushPc, savedPc, pc, instrValid} !== {1'b1, 32'h20, 32'h2, 1'b0})
      $display("FAIL int_take got push=%b saved=%h pc=%h valid=%b exp push=1 saved=20 pc=2 valid=0", pushPc, savedPc, pc, instrValid);
    else n_pass++;
    interruptBit = 1'b1;
    tick();
    interruptBit = 1'b0;
    n_checks++; if ({pc, pushPc} !== {32'h3, 1'b0}) $display("FAIL int_lo got pc=%h push=%b exp pc=3 push=0", pc, pushPc); else n_pass++;
    tick();
    n_checks++; if ({pc, instrValid} !== {32'h80, 1'b0}) $display("FAIL int_vector got pc=%h valid=%b exp pc=80 valid=0", pc, instrValid); else n_pass++;
    sb.push_back(exp_t'{16'h0050, 16'h0000, 32'h80, 32'h81});
    wait_valid(3, cyc);
    sb_compare("handler_ifid");
    n_checks++; if (pushPc !== 1'b0) $display("FAIL nested_deferred got push=%b exp=0", pushPc); else n_pass++;
    tick();
    n_checks++;
    if ({pushPc, savedPc, pc} !== {1'b1, 32'h81, 32'h2})
      $display("FAIL nested_take got push=%b saved=%h pc=%h exp push=1 saved=81 pc=2", pushPc, savedPc, pc);
    else n_pass++;
    tick();
    n_checks++; if (pushPc !== 1'b0) $display("FAIL push_pulse got=%b exp=0", pushPc); else n_pass++;
    tick();
    n_checks++; if (pc !== 32'h80) $display("FAIL nested_vector got=%h exp=%h", pc, 32'h80); else n_pass++;
  endtask

  task automatic test_int_in_imm();
    jumpBit = 1'b1;
    jumpTarget = 32'h30;
    tick();
    jumpBit = 1'b0;
    tick();
    n_checks++; if (pc !== 32'h31) $display("FAIL imm_fetch_pc got=%h exp=%h", pc, 32'h31); else n_pass++;
    interruptBit = 1'b1;
    sb.push_back(exp_t'{16'h0003, 16'h00AA, 32'h30, 32'h32});
    wait_valid(3, cyc);
    interruptBit = 1'b0;
    sb_compare("imm_before_int_ifid");
    n_checks++; if ({pushPc, pc} !== {1'b0, 32'h32}) $display("FAIL imm_not_interrupted got push=%b pc=%h exp push=0 pc=32", pushPc, pc); else n_pass++;
    tick();
    n_checks++;
    if ({pushPc, savedPc, pc} !== {1'b1, 32'h32, 32'h2})
      $display("FAIL int_after_imm got push=%b saved=%h pc=%h exp push=1 saved=32 pc=2", pushPc, savedPc, pc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    interruptBit = 1'b1;
    tick();
    interruptBit = 1'b0;
    n_checks++; if (dut.state_q !== INT_LO) $display("FAIL mid_state_int_lo got=%0d exp=%0d", dut.state_q, INT_LO); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if ({dut.state_q, pc, dut.int_pending_q} !== {RST_HI, 32'h0, 1'b0}) $display("FAIL mid_reset_state got state=%0d pc=%h pend=%b exp state=0 pc=0 pend=0", dut.state_q, pc, dut.int_pending_q); else n_pass++;
    n_checks++;
    if ({instrValid, pushPc, instruction, immediate, samePc, nextPc, savedPc} !== 130'h0)
      $display("FAIL mid_reset_outputs got valid=%b push=%b instr=%h imm=%h same=%h next=%h saved=%h exp all zero",
               instrValid, pushPc, instruction, immediate, samePc, nextPc, savedPc);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    tick();
    tick();
    n_checks++; if (pc !== 32'h10) $display("FAIL reboot_pc got=%h exp=%h", pc, 32'h10); else n_pass++;
    jumpBit = 1'b1;
    jumpTarget = 32'hFFFF_FFFF;
    tick();
    jumpBit = 1'b0;
    sb.push_back(exp_t'{16'h0006, 16'h0000, 32'hFFFF_FFFF, 32'h0});
    wait_valid(3, cyc);
    sb_compare("wrap_ifid");
    n_checks++; if (pc !== 32'h0) $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    jumpBit = 1'b0;
    jumpTarget = 32'h0;
    interruptBit = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h01] = 16'h0010;
    mem[8'h03] = 16'h0080;
    mem[8'h10] = 16'h3811;
    mem[8'h11] = 16'h0004;
    mem[8'h12] = 16'h1234;
    mem[8'h13] = 16'h2001;
    mem[8'h20] = 16'h0100;
    mem[8'h30] = 16'h0003;
    mem[8'h31] = 16'h00AA;
    mem[8'h40] = 16'h0042;
    mem[8'h80] = 16'h0050;
    mem[8'h81] = 16'h0060;
    mem[8'hFF] = 16'h0006;

    test_reset();
    test_boot();
    test_two_word();
    test_one_word();
    test_stall_jump();
    test_interrupt();
    test_int_in_imm();
    test_reset_mid();
    test_wrap();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
